// File: rtl/inc_counter_n.sv
// inc_counter_n: loadable N-bit modulo up-counter with a terminal-count
// pulse and a sticky rollover flag. All outputs are registered.
module inc_counter_n #(
  parameter int N        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  input  logic         clr_ovf,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  logic         limit_hit;
  logic [N-1:0] count_inc;
  logic [N-1:0] count_nxt;
  logic         tc_nxt;
  logic         ovf_nxt;

  // Limit compare and increment; the carry-out of the add is dropped, so a
  // count above the limit runs through all-ones to zero with no event.
  always_comb begin
    limit_hit = en && !load && (count == limit);
    count_inc = count + {{(N-1){1'b0}}, 1'b1};
  end

  // Next-state selection in priority order: load, limit event, increment, hold.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = load_val;
    end else if (limit_hit) begin
      count_nxt = SATURATE ? count : '0;
      tc_nxt    = 1'b1;
    end else if (en) begin
      count_nxt = count_inc;
    end
  end

  // Sticky flag: a limit event in the same cycle as clr_ovf keeps it set.
  always_comb begin
    ovf_nxt = ovf;
    if (limit_hit) begin
      ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_inc_counter_n.sv
// Scoreboard bench for inc_counter_n: one wrap-mode and one saturate-mode
// instance share stimulus; a reference model pushes expectations per cycle.
module tb_inc_counter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [7:0] load_val = 8'h00, limit = 8'h00;
  logic [7:0] count_w, count_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int total = 0;
  int bad = 0;

  typedef struct {
    int c[2];
    bit t[2];
    bit o[2];
  } exp_t;

  exp_t q[$];

  int mc[2];
  bit mt[2];
  bit mo[2];

  inc_counter_n #(.N(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf), .count(count_w), .tc(tc_w), .ovf(ovf_w));

  inc_counter_n #(.N(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf), .count(count_s), .tc(tc_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; mt[i] = 1'b0; mo[i] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus and push what both counters must show after it.
  task automatic step(input bit e, input bit ld, input int lv, input int lim, input bit clr);
    exp_t x;
    @(negedge clk);
    en = e; load = ld; load_val = lv[7:0]; limit = lim[7:0]; clr_ovf = clr;
    for (int i = 0; i < 2; i++) begin
      bit hit;
      hit = !ld && e && (mc[i] == lim);
      if (ld) begin
        mc[i] = lv; mt[i] = 1'b0;
      end else if (hit) begin
        mc[i] = (i == 1) ? mc[i] : 0; mt[i] = 1'b1;
      end else if (e) begin
        mc[i] = (mc[i] + 1) % 256; mt[i] = 1'b0;
      end else begin
        mt[i] = 1'b0;
      end
      if (hit) mo[i] = 1'b1;
      else if (clr) mo[i] = 1'b0;
      x.c[i] = mc[i]; x.t[i] = mt[i]; x.o[i] = mo[i];
    end
    q.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: compare every cycle for which an expectation is queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count_wrap", {24'b0, count_w}, e.c[0]);
      chk("tc_wrap",    {31'b0, tc_w},    {31'b0, e.t[0]});
      chk("ovf_wrap",   {31'b0, ovf_w},   {31'b0, e.o[0]});
      chk("count_sat",  {24'b0, count_s}, e.c[1]);
      chk("tc_sat",     {31'b0, tc_s},    {31'b0, e.t[1]});
      chk("ovf_sat",    {31'b0, ovf_s},   {31'b0, e.o[1]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("reset_count", {24'b0, count_w}, 32'h0);
    chk("reset_tc",    {31'b0, tc_w},    32'h0);
    chk("reset_ovf",   {31'b0, ovf_s},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic wrap, limit 5
    step(0, 1, 0, 5, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 5, 0);

    // load priority then natural wrap past limit
    step(0, 1, 3, 5, 0);
    step(1, 1, 'hA0, 5, 0);
    for (int i = 0; i < 116; i++) step(1, 0, 0, 'h10, 0);

    // saturate behaviour and clr_ovf vs limit event
    step(0, 1, 0, 3, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 3, 0);
    step(1, 0, 0, 3, 1);
    step(0, 0, 0, 3, 1);

    // full range and enable toggling
    step(0, 1, 'hFE, 'hFF, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 'hFF, 0);
    step(1, 0, 0, 'hFF, 0);
    step(0, 0, 0, 'hFF, 0);
    step(1, 0, 0, 'hFF, 0);

    // limit 0 with en held
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

    // asynchronous reset mid-count
    step(0, 1, 'h37, 0, 0);
    step(0, 0, 0, 'h40, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count_wrap", {24'b0, count_w}, 32'h0);
    chk("async_rst_count_sat",  {24'b0, count_s}, 32'h0);
    chk("async_rst_tc",         {31'b0, tc_w | tc_s},  32'h0);
    chk("async_rst_ovf",        {31'b0, ovf_w | ovf_s}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit e, ld, clr;
      int lim;
      e   = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 9) == 0);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      step(e, ld, $urandom_range(0, 255), lim, clr);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
